// File: rtl/cus19_decode_stage.sv
// ============================================================================
// Module   : cus19_decode_stage
// Brief    : Instruction decode stage for the 19-bit core.
//            Fetch words are queued in a DEPTH-entry FIFO, decoded into their
//            fields and presented in a valid/ready output register.
//            Optional macro CUS19_ILLEGAL_TRAP_EN enables illegal_out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cus19_decode_stage #(
    parameter int DEPTH = 4,
    parameter int IMM_W = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_in,
    input  logic [18:0]                instr_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 opcode_out,
    output logic [3:0]                 funct_out,
    output logic [3:0]                 rs1_out,
    output logic [3:0]                 rs2_out,
    output logic [3:0]                 rd_out,
    output logic [3:0]                 wb_addr_out,
    output logic                       wb_en_out,
    output logic [IMM_W-1:0]           imm_addr_out,
    output logic                       illegal_out,
    output logic [$clog2(DEPTH):0]     fifo_count_out
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    generate
        if (IMM_W < 11) begin : g_bad_imm_w
            $error("cus19_decode_stage: IMM_W must be at least 11");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("cus19_decode_stage: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [18:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_out_valid;

    logic               w_push;
    logic               w_pop;
    logic [18:0]        w_instr;

    logic [2:0]         w_opcode;
    logic [3:0]         w_funct;
    logic [3:0]         w_rs1;
    logic [3:0]         w_rs2;
    logic [3:0]         w_rd;
    logic [3:0]         w_wb_addr;
    logic               w_wb_en;
    logic [IMM_W-1:0]   w_imm;
`ifdef CUS19_ILLEGAL_TRAP_EN
    logic               w_illegal;
    logic               r_illegal;
`endif

    // Readiness depends only on registered occupancy, so a pop cannot refill a full FIFO in the same cycle.
    assign in_ready       = (r_count != c_CNT_W'(DEPTH));
    assign out_valid      = r_out_valid;
    assign fifo_count_out = r_count;
    assign w_push         = in_valid && in_ready && !flush_in;
    assign w_pop          = (r_count != '0) && (!r_out_valid || out_ready) && !flush_in;
    assign w_instr        = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= instr_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_comb begin
        w_opcode  = '0;
        w_funct   = '0;
        w_rs1     = '0;
        w_rs2     = '0;
        w_rd      = '0;
        w_wb_addr = '0;
        w_wb_en   = 1'b0;
        w_imm     = '0;
`ifdef CUS19_ILLEGAL_TRAP_EN
        w_illegal = 1'b0;
`endif
        case (w_instr[2:0])
            3'b000: begin
                w_opcode  = w_instr[2:0];
                w_funct   = w_instr[6:3];
                w_rs2     = w_instr[10:7];
                w_rs1     = w_instr[14:11];
                w_rd      = w_instr[18:15];
                w_wb_addr = w_instr[18:15];
                w_wb_en   = 1'b1;
            end
            3'b001: begin
                w_opcode     = w_instr[2:0];
                w_funct      = {3'b000, w_instr[3]};
                w_rs1        = w_instr[7:4];
                w_wb_addr    = w_instr[7:4];
                w_wb_en      = ~w_instr[3];
                w_imm[10:0]  = w_instr[18:8];
            end
            3'b010: begin
                w_opcode     = w_instr[2:0];
                w_funct      = {2'b00, w_instr[4:3]};
                w_imm[10:0]  = w_instr[15:5];
            end
            3'b011: begin
                w_opcode     = w_instr[2:0];
                w_funct      = {3'b000, w_instr[3]};
                w_rs2        = w_instr[7:4];
                w_rs1        = w_instr[11:8];
                w_imm        = {IMM_W{w_instr[18]}};
                w_imm[6:0]   = w_instr[18:12];
            end
            3'b100: begin
                w_opcode  = w_instr[2:0];
                w_funct   = {3'b000, w_instr[3]};
                w_rs2     = w_instr[7:4];
                w_rs1     = w_instr[11:8];
            end
            default: begin
`ifdef CUS19_ILLEGAL_TRAP_EN
                w_illegal = 1'b1;
`endif
            end
        endcase
    end

    // Fields only change on a load; a drain with the FIFO empty just drops out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            opcode_out   <= '0;
            funct_out    <= '0;
            rs1_out      <= '0;
            rs2_out      <= '0;
            rd_out       <= '0;
            wb_addr_out  <= '0;
            wb_en_out    <= 1'b0;
            imm_addr_out <= '0;
        end else if (flush_in) begin
            r_out_valid  <= 1'b0;
        end else if (w_pop) begin
            r_out_valid  <= 1'b1;
            opcode_out   <= w_opcode;
            funct_out    <= w_funct;
            rs1_out      <= w_rs1;
            rs2_out      <= w_rs2;
            rd_out       <= w_rd;
            wb_addr_out  <= w_wb_addr;
            wb_en_out    <= w_wb_en;
            imm_addr_out <= w_imm;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

`ifdef CUS19_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (!flush_in && w_pop) begin
            r_illegal <= w_illegal;
        end
    end
    assign illegal_out = r_illegal;
`else
    assign illegal_out = 1'b0;
`endif

endmodule

`default_nettype wire
